// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encodings, control states, enable vector and opcode classing shared by the ALU control path
package cpu_pkg;
    localparam int IR_W = 32;
    localparam int OP_W = 5;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {RESET_S, T0, T1, T2, T3, T4, T5, T6, HALTED} state_t;

    typedef enum logic [2:0] {CL_R3, CL_IMM, CL_MD, CL_UN, CL_NOP, CL_HALT, CL_RSV} op_class_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
        logic c_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        return (op inside {[OP_ADD:OP_OR]})   ? CL_R3  :
               (op inside {[OP_ADDI:OP_ORI]}) ? CL_IMM :
               (op inside {OP_MUL, OP_DIV})   ? CL_MD  :
               (op inside {OP_NEG, OP_NOT})   ? CL_UN  :
               (op == OP_NOP)                 ? CL_NOP :
               (op == OP_HALT)                ? CL_HALT : CL_RSV;
    endfunction
endpackage

// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: IR/memory handshake inputs and datapath enables between control unit and datapath
interface alu_control_unit_if #(
    parameter int IR_W = 32,
    parameter int OP_W = 5
);
    logic [IR_W-1:0] ir;
    logic            mem_ready;
    logic [OP_W-1:0] alu_op;
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out;
    logic gra, grb, grc, r_in, r_out;
    logic run, illegal_op;

    modport master (
        input  ir, mem_ready,
        output alu_op, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out,
               gra, grb, grc, r_in, r_out, run, illegal_op
    );

    modport slave (
        output ir, mem_ready,
        input  alu_op, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out,
               gra, grb, grc, r_in, r_out, run, illegal_op
    );
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational (state, opcode) to datapath enable vector
module control_decode import cpu_pkg::*; (
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    output ctrl_t           en
);
    op_class_t cls;
    assign cls = op_class(op);
    always_comb begin
        en = '0;
        case (state)
            T0: begin
                en.pc_out = 1'b1;
                en.mar_in = 1'b1;
                en.inc_pc = 1'b1;
                en.z_in   = 1'b1;
            end
            T1: begin
                en.zlow_out = 1'b1;
                en.pc_in    = 1'b1;
                en.read     = 1'b1;
                en.mdr_in   = 1'b1;
            end
            T2: begin
                en.mdr_out = 1'b1;
                en.ir_in   = 1'b1;
            end
            T3: begin
                en.r_out = 1'b1;
                en.gra   = cls == CL_MD;
                en.grb   = cls != CL_MD;
                en.y_in  = cls != CL_UN;
                en.z_in  = cls == CL_UN;
            end
            T4: begin
                en.zlow_out = cls == CL_UN;
                en.gra      = cls == CL_UN;
                en.r_in     = cls == CL_UN;
                en.grb      = cls == CL_MD;
                en.grc      = cls == CL_R3;
                en.r_out    = cls == CL_R3 || cls == CL_MD;
                en.c_out    = cls == CL_IMM;
                en.z_in     = cls != CL_UN;
            end
            T5: begin
                en.zlow_out = 1'b1;
                en.lo_in    = cls == CL_MD;
                en.gra      = cls != CL_MD;
                en.r_in     = cls != CL_MD;
            end
            T6: begin
                en.zhigh_out = 1'b1;
                en.hi_in     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: multi-cycle fetch/decode/execute sequencer for ALU-class instructions
module alu_control_unit import cpu_pkg::*; #(
    parameter int IR_W = 32,
    parameter int OP_W = 5
) (
    input logic clk,
    input logic clear,
    alu_control_unit_if.master bus
);
    state_t          state;
    logic [OP_W-1:0] op, op_q;
    logic            illegal_q;
    op_class_t       cls, cls_q;
    ctrl_t           en;

    assign op    = bus.ir[IR_W-1 -: OP_W];
    assign cls   = op_class(op);
    assign cls_q = op_class(op_q);

    // opcode is latched as IR loads so later ir changes cannot redirect the sequence
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= RESET_S;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= state == T2 && cls == CL_RSV;
            if (state == T2) op_q <= op;
            case (state)
                RESET_S: state <= T0;
                T0:      state <= T1;
                T1:      state <= bus.mem_ready ? T2 : T1;
                T2:      state <= (cls == CL_NOP || cls == CL_RSV) ? T0 :
                                  (cls == CL_HALT) ? HALTED : T3;
                T3:      state <= T4;
                T4:      state <= (cls_q == CL_UN) ? T0 : T5;
                T5:      state <= (cls_q == CL_MD) ? T6 : T0;
                T6:      state <= T0;
                default: ;
            endcase
        end
    end

    control_decode u_decode (
        .state (state),
        .op    (op_q),
        .en    (en)
    );

    assign bus.alu_op     = (state inside {T3, T4, T5, T6}) ? op : OP_ADD;
    assign bus.run        = state != RESET_S && state != HALTED;
    assign bus.illegal_op = illegal_q;
    assign bus.pc_out     = en.pc_out;
    assign bus.mar_in     = en.mar_in;
    assign bus.inc_pc     = en.inc_pc;
    assign bus.pc_in      = en.pc_in & bus.mem_ready;
    assign bus.read       = en.read;
    assign bus.mdr_in     = en.mdr_in;
    assign bus.mdr_out    = en.mdr_out;
    assign bus.ir_in      = en.ir_in;
    assign bus.y_in       = en.y_in;
    assign bus.z_in       = en.z_in;
    assign bus.zlow_out   = en.zlow_out;
    assign bus.zhigh_out  = en.zhigh_out;
    assign bus.hi_in      = en.hi_in;
    assign bus.lo_in      = en.lo_in;
    assign bus.c_out      = en.c_out;
    assign bus.gra        = en.gra;
    assign bus.grb        = en.grb;
    assign bus.grc        = en.grc;
    assign bus.r_in       = en.r_in;
    assign bus.r_out      = en.r_out;
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed instruction sequences checked cycle by cycle against hand-written enable sets
module tb_alu_control_unit;
    import cpu_pkg::*;

    localparam logic [21:0] RUN     = 22'h200000;
    localparam logic [21:0] ILL     = 22'h100000;
    localparam logic [21:0] PC_OUT  = 22'h080000;
    localparam logic [21:0] MAR_IN  = 22'h040000;
    localparam logic [21:0] INC_PC  = 22'h020000;
    localparam logic [21:0] PC_IN   = 22'h010000;
    localparam logic [21:0] READ    = 22'h008000;
    localparam logic [21:0] MDR_IN  = 22'h004000;
    localparam logic [21:0] MDR_OUT = 22'h002000;
    localparam logic [21:0] IR_IN   = 22'h001000;
    localparam logic [21:0] Y_IN    = 22'h000800;
    localparam logic [21:0] Z_IN    = 22'h000400;
    localparam logic [21:0] ZLOW    = 22'h000200;
    localparam logic [21:0] ZHIGH   = 22'h000100;
    localparam logic [21:0] HI_IN   = 22'h000080;
    localparam logic [21:0] LO_IN   = 22'h000040;
    localparam logic [21:0] C_OUT   = 22'h000020;
    localparam logic [21:0] GRA     = 22'h000010;
    localparam logic [21:0] GRB     = 22'h000008;
    localparam logic [21:0] GRC     = 22'h000004;
    localparam logic [21:0] R_IN    = 22'h000002;
    localparam logic [21:0] R_OUT   = 22'h000001;
    localparam logic [21:0] F0  = RUN | PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [21:0] F1W = RUN | ZLOW | READ | MDR_IN;
    localparam logic [21:0] F1  = F1W | PC_IN;
    localparam logic [21:0] F2  = RUN | MDR_OUT | IR_IN;

    logic clk = 1'b0;
    logic clear;
    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    int t0;
    logic [21:0] obs;

    alu_control_unit_if bus ();

    alu_control_unit dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    assign obs = {bus.run, bus.illegal_op, bus.pc_out, bus.mar_in, bus.inc_pc, bus.pc_in,
                  bus.read, bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.z_in,
                  bus.zlow_out, bus.zhigh_out, bus.hi_in, bus.lo_in, bus.c_out,
                  bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input state_t st, input logic [21:0] ev);
        @(negedge clk);
        #1;
        chk({tag, "_state"}, 32'(dut.state), 32'(st));
        chk({tag, "_en"}, 32'(obs), 32'(ev));
    endtask

    initial begin
        clear = 1'b1;
        bus.ir = {OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0};
        bus.mem_ready = 1'b1;
        #3 clear = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(dut.state), 32'(RESET_S));
        chk("reset_en", 32'(obs), 32'(0));
        chk("reset_op", 32'(bus.alu_op), 32'(5'b00011));
        clear = 1'b1;

        cyc("add_t0", T0, F0);
        cyc("add_t1", T1, F1);
        cyc("add_t2", T2, F2);
        cyc("add_t3", T3, RUN | GRB | R_OUT | Y_IN);
        cyc("add_t4", T4, RUN | GRC | R_OUT | Z_IN);
        chk("add_t4_op", 32'(bus.alu_op), 32'(5'b00011));
        cyc("add_t5", T5, RUN | ZLOW | GRA | R_IN);

        cyc("addi_t0", T0, F0);
        t0 = ncyc;
        bus.ir = {OP_ADDI, 4'd4, 4'd5, 19'd7};
        bus.mem_ready = 1'b0;
        repeat (3) cyc("addi_t1w", T1, F1W);
        @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        cyc("addi_t1", T1, F1);
        cyc("addi_t2", T2, F2);
        cyc("addi_t3", T3, RUN | GRB | R_OUT | Y_IN);
        cyc("addi_t4", T4, RUN | C_OUT | Z_IN);
        cyc("addi_t5", T5, RUN | ZLOW | GRA | R_IN);

        cyc("mul_t0", T0, F0);
        chk("addi_cpi", 32'(ncyc - t0), 32'd9);
        t0 = ncyc;
        bus.ir = {OP_MUL, 4'd2, 4'd3, 19'd0};
        chk("mul_t0_op", 32'(bus.alu_op), 32'(5'b00011));
        cyc("mul_t1", T1, F1);
        cyc("mul_t2", T2, F2);
        cyc("mul_t3", T3, RUN | GRA | R_OUT | Y_IN);
        chk("mul_t3_op", 32'(bus.alu_op), 32'(5'b01110));
        cyc("mul_t4", T4, RUN | GRB | R_OUT | Z_IN);
        cyc("mul_t5", T5, RUN | ZLOW | LO_IN);
        cyc("mul_t6", T6, RUN | ZHIGH | HI_IN);

        cyc("rsv_t0", T0, F0);
        chk("mul_cpi", 32'(ncyc - t0), 32'd7);
        bus.ir = {5'b10010, 27'd0};
        cyc("rsv_t1", T1, F1);
        cyc("rsv_t2", T2, F2);
        cyc("rsv_ill", T0, F0 | ILL);
        bus.ir = {OP_NEG, 4'd6, 4'd7, 19'd0};
        cyc("neg_t1", T1, F1);
        cyc("neg_t2", T2, F2);
        cyc("neg_t3", T3, RUN | GRB | R_OUT | Z_IN);
        cyc("neg_t4", T4, RUN | ZLOW | GRA | R_IN);

        cyc("nop_t0", T0, F0);
        bus.ir = {OP_NOP, 27'd0};
        cyc("nop_t1", T1, F1);
        cyc("nop_t2", T2, F2);

        cyc("sub_t0", T0, F0);
        bus.ir = {OP_SUB, 4'd1, 4'd2, 4'd3, 15'd0};
        cyc("sub_t1", T1, F1);
        cyc("sub_t2", T2, F2);
        cyc("sub_t3", T3, RUN | GRB | R_OUT | Y_IN);
        cyc("sub_t4", T4, RUN | GRC | R_OUT | Z_IN);
        chk("sub_t4_op", 32'(bus.alu_op), 32'(5'b00100));
        #1 clear = 1'b0;
        #1;
        chk("async_state", 32'(dut.state), 32'(RESET_S));
        chk("async_en", 32'(obs), 32'(0));
        chk("async_op", 32'(bus.alu_op), 32'(5'b00011));
        repeat (2) cyc("sub_rst", RESET_S, 22'h0);
        clear = 1'b1;

        cyc("halt_t0", T0, F0);
        bus.ir = {OP_HALT, 27'd0};
        cyc("halt_t1", T1, F1);
        cyc("halt_t2", T2, F2);
        repeat (20) cyc("halted", HALTED, 22'h0);
        chk("halted_op", 32'(bus.alu_op), 32'(5'b00011));
        clear = 1'b0;
        #2 clear = 1'b1;
        cyc("restart_t0", T0, F0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_control_unit.md
# alu_control_unit

Multi-cycle control FSM that sequences the ALU and its Y/Z registers for every ALU-class instruction.
- Drives instruction fetch (PC→MAR, memory read, MDR→IR), decodes IR[31:27], and steps the bus/register enables through execute and write-back.
- Sits between the instruction register and the datapath; it is the only source of the ALU `opcode` input.
- Memory, branch and I/O opcodes are reserved in this revision and are flagged, not executed.

## Interface
Parameters:
- `IR_W`, 32, instruction width
- `OP_W`, 5, opcode width (IR[31:27])

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `clear`  in  1  reset, asynchronous, active-low
- `ir`  in  32  current IR contents
- `mem_ready`  in  1  memory read handshake; high = MDR data valid this cycle
- `alu_op`  out  5  opcode to ALU
- `pc_out`, `mar_in`, `inc_pc`, `pc_in`, `read`, `mdr_in`, `mdr_out`, `ir_in`  out  1 each  fetch enables
- `y_in`, `z_in`, `zlow_out`, `zhigh_out`, `hi_in`, `lo_in`, `c_out`  out  1 each  ALU-side enables
- `gra`, `grb`, `grc`, `r_in`, `r_out`  out  1 each  register-file select/enables
- `run`  out  1  high while executing; low in reset and after halt
- `illegal_op`  out  1  one-cycle pulse on decode of a reserved opcode

## Operation
- States: RESET_S, T0, T1, T2, T3, T4, T5, T6, HALTED.
- Opcode classes:
  - R3: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - IMM: addi 01011, andi 01100, ori 01101.
  - MD: mul 01110, div 01111.
  - UN: neg 10000, not 10001.
  - nop 11001; halt 11010.
  - Reserved: everything else.
- Fetch:
  - T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`.
  - T1: `zlow_out`, `pc_in`, `read`, `mdr_in`. Hold T1 with `read`/`mdr_in` asserted until `mem_ready`=1. `pc_in` asserts only in the exit cycle.
  - T2: `mdr_out`, `ir_in`.
- Decode at T2 exit uses `ir` sampled on the following edge, i.e. the T3 decisions use the new IR:
  - nop → T0.
  - halt → HALTED.
  - reserved → T0 with `illegal_op` pulsed in that T0 cycle.
- R3:
  - T3: `grb`, `r_out`, `y_in`.
  - T4: `grc`, `r_out`, `z_in`.
  - T5: `zlow_out`, `gra`, `r_in`; then → T0.
- IMM: as R3 except T4 asserts `c_out`, `z_in`.
- UN:
  - T3: `grb`, `r_out`, `z_in`.
  - T4: `zlow_out`, `gra`, `r_in`; then → T0.
- MD:
  - T3: `gra`, `r_out`, `y_in`.
  - T4: `grb`, `r_out`, `z_in`.
  - T5: `zlow_out`, `lo_in`.
  - T6: `zhigh_out`, `hi_in`; then → T0.
- `alu_op` = ir[31:27] in T3–T6; = 00011 (add) in T0–T2, RESET_S and HALTED.
- HALTED is absorbing until `clear` asserts. All enables are 0 there.
- Outputs are a combinational decode of (state, ir[31:27]). The datapath samples them on the next rising edge.

## Timing
- While `clear`=0:
  - state = RESET_S.
  - Every output is 0, including `run` and `illegal_op`.
  - `alu_op` = 00011.
- First rising edge with `clear`=1: RESET_S → T0; `run`=1 from then on.
- CPI with `mem_ready` high in the first T1 cycle:
  - R3/IMM 6.
  - UN 5.
  - MD 7.
  - nop/reserved 3.
  - halt 3, then HALTED.
- Each extra low-`mem_ready` cycle adds 1.
- At most one `r_in`/`lo_in`/`hi_in` per cycle. `z_in` is never asserted in the same cycle as `zlow_out` or `zhigh_out`, except in T1 (`z_in`=0 there).
- `clear` falling mid-instruction: state goes to RESET_S and outputs to 0 immediately, without a clock edge. No partial write-back completes.
- `ir` changes outside T2→T3 are ignored for sequencing. `alu_op` tracks `ir` live, so the datapath holds IR stable.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams matching the ALU encodings;
  - state enum;
  - opcode-class function `op_class(op)`.
- One sub-module `control_decode`: purely combinational, (state, opcode) → enable vector.
- `alu_control_unit` holds only the state register, the `mem_ready` wait and the halt/illegal logic.

## Test plan
- Reset, then add R1,R2,R3 (ir=0x18918000), `mem_ready`=1:
  - states T0,T1,T2,T3,T4,T5,T0;
  - `alu_op`=00011 in T4;
  - `r_in`·`gra` only in T5.
- addi R4,R5,7 with `mem_ready` low for 3 T1 cycles:
  - T1 held 4 cycles with `read`=1, `pc_in` only in the last;
  - `c_out`=1 in T4; CPI=9.
- mul R2,R3 (opcode 01110): `lo_in` in T5, `hi_in` in T6; `gra` with `y_in` in T3; CPI=7.
- Opcode 10010 (reserved):
  - returns to T0 after T2;
  - `illegal_op` high exactly 1 cycle;
  - no `r_in`/`z_in` beyond fetch.
- halt (11010):
  - `run` falls on the edge leaving T2;
  - HALTED held for 20 cycles with all enables 0;
  - pulse `clear` → T0.
- Assert `clear`=0 asynchronously mid-T4 of a sub:
  - all outputs 0 before the next edge;
  - no `r_in` ever for that instruction.
